// File: rtl/letc_core_fetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : letc_core_fetch_buffer_if                                    |
// | Description : Bundle of the fetch buffer's MMU instruction port, s1 output |
// |               handshake and redirect/halt controls.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

interface letc_core_fetch_buffer_if;
    // MMU instruction request/response
    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        i_rsp_ready;
    logic [31:0] i_rsp_instr;
    logic        i_rsp_illegal;
    // Head entry towards s1
    logic        o_out_valid;
    logic [31:0] o_out_pc;
    logic [31:0] o_out_instr;
    logic        o_out_illegal;
    logic        i_out_ready;
    // Redirect and halt
    logic        i_branch_en;
    logic [31:0] i_branch_target;
    logic        i_halt_req;

    // The fetch buffer itself
    modport slave (
        output o_req_valid, o_req_addr,
        input  i_rsp_ready, i_rsp_instr, i_rsp_illegal,
        output o_out_valid, o_out_pc, o_out_instr, o_out_illegal,
        input  i_out_ready,
        input  i_branch_en, i_branch_target, i_halt_req
    );

    // The surrounding core (MMU, s1, branch/halt sources)
    modport master (
        input  o_req_valid, o_req_addr,
        output i_rsp_ready, i_rsp_instr, i_rsp_illegal,
        input  o_out_valid, o_out_pc, o_out_instr, o_out_illegal,
        output i_out_ready,
        output i_branch_en, i_branch_target, i_halt_req
    );
endinterface

`default_nettype wire

// File: rtl/letc_core_fetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : letc_core_fetch_buffer                                       |
// | Description : Sequential instruction fetcher with a DEPTH-entry FIFO in    |
// |               front of s1. Handles branch redirects (dropping stale        |
// |               responses), fetch faults and halt requests.                  |
// |               Optional: LETC_FETCH_BUF_BYPASS_EN presents a response       |
// |               combinationally when the FIFO is empty.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module letc_core_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    letc_core_fetch_buffer_if.slave fb
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        c_FETCH   = 2'd0,
        c_DISCARD = 2'd1,
        c_FAULT   = 2'd2,
        c_HALTED  = 2'd3
    } state_t;

    state_t               r_state;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_discard_addr;
    logic                 r_halt_pending;
    logic                 r_req_pend;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [31:0]          r_pc_mem    [DEPTH];
    logic [31:0]          r_instr_mem [DEPTH];
    logic                 r_ill_mem   [DEPTH];

    state_t               w_state_next;
    logic [31:0]          w_fetch_pc_next;
    logic [31:0]          w_discard_addr_next;
    logic                 w_halt_pending_next;
    logic                 w_req_pend_next;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_req_valid;
    logic                 w_rsp_take;
    logic                 w_accept;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_pop;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A request already presented (r_req_pend) is held even if a halt is now
    // pending; halt_pending only blocks new requests.
    assign w_req_valid = !i_rst &&
                         (((r_state == c_FETCH) &&
                           (r_req_pend || (!w_full && !r_halt_pending))) ||
                          (r_state == c_DISCARD));

    assign w_rsp_take = w_req_valid && fb.i_rsp_ready;
    assign w_accept   = (r_state == c_FETCH) && w_rsp_take && !fb.i_branch_en;

`ifdef LETC_FETCH_BUF_BYPASS_EN
    assign w_bypass = w_empty && w_accept;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed response that s1 takes right away never enters the FIFO
    assign w_push = w_accept && !(w_bypass && fb.i_out_ready);
    assign w_pop  = !w_empty && fb.i_out_ready;

    assign fb.o_req_valid   = w_req_valid;
    assign fb.o_req_addr    = (r_state == c_DISCARD) ? r_discard_addr : r_fetch_pc;
    assign fb.o_out_valid   = !i_rst && (!w_empty || w_bypass);
    assign fb.o_out_pc      = w_bypass ? r_fetch_pc       : r_pc_mem[r_rd_ptr];
    assign fb.o_out_instr   = w_bypass ? fb.i_rsp_instr   : r_instr_mem[r_rd_ptr];
    assign fb.o_out_illegal = w_bypass ? fb.i_rsp_illegal : r_ill_mem[r_rd_ptr];

    // Next state, fetch PC and halt bookkeeping; a branch overrides everything
    always_comb begin
        w_state_next        = r_state;
        w_fetch_pc_next     = r_fetch_pc;
        w_discard_addr_next = r_discard_addr;
        w_halt_pending_next = r_halt_pending;
        w_req_pend_next     = 1'b0;
        if (fb.i_branch_en) begin
            w_fetch_pc_next     = fb.i_branch_target;
            w_halt_pending_next = 1'b0;
            if ((r_state == c_DISCARD) && !fb.i_rsp_ready) begin
                // Stale request still in flight; keep waiting for it
                w_state_next        = c_DISCARD;
                w_halt_pending_next = fb.i_halt_req;
            end else if ((r_state == c_FETCH) && w_req_valid && !fb.i_rsp_ready) begin
                w_state_next        = c_DISCARD;
                w_discard_addr_next = r_fetch_pc;
                w_halt_pending_next = fb.i_halt_req;
            end else begin
                w_state_next = fb.i_halt_req ? c_HALTED : c_FETCH;
            end
        end else begin
            unique case (r_state)
                c_FETCH: begin
                    if (w_rsp_take) begin
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                        if (fb.i_rsp_illegal) begin
                            w_state_next        = c_FAULT;
                            w_halt_pending_next = 1'b0;
                        end else if (r_halt_pending || fb.i_halt_req) begin
                            w_state_next        = c_HALTED;
                            w_halt_pending_next = 1'b0;
                        end
                    end else begin
                        w_req_pend_next = w_req_valid;
                        if (fb.i_halt_req) begin
                            if (w_req_valid) begin
                                w_halt_pending_next = 1'b1;
                            end else begin
                                w_state_next = c_HALTED;
                            end
                        end
                    end
                end
                c_DISCARD: begin
                    if (fb.i_rsp_ready) begin
                        w_state_next        = (r_halt_pending || fb.i_halt_req) ? c_HALTED : c_FETCH;
                        w_halt_pending_next = 1'b0;
                    end else if (fb.i_halt_req) begin
                        w_halt_pending_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= c_FETCH;
            r_fetch_pc     <= RESET_PC;
            r_discard_addr <= RESET_PC;
            r_halt_pending <= 1'b0;
            r_req_pend     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_fetch_pc     <= w_fetch_pc_next;
            r_discard_addr <= w_discard_addr_next;
            r_halt_pending <= w_halt_pending_next;
            r_req_pend     <= w_req_pend_next;
        end
    end

    // FIFO pointers and occupancy; a branch flushes with priority over push/pop
    always_ff @(posedge i_clk) begin
        if (i_rst || fb.i_branch_en) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= fb.i_rsp_instr;
            r_ill_mem[r_wr_ptr]   <= fb.i_rsp_illegal;
        end
    end

endmodule

`default_nettype wire
